execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter SHAMT_W, default $clog2(XLEN), shift-amount width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operation presented.
REQ-006 in_ready  output  1  stage can accept; transfer when in_valid && in_ready.
REQ-007 pc, imm  input  XLEN each  instruction address, sign-extended immediate.
REQ-008 rs1_data, rs2_data  input  XLEN each  register-file operands.
REQ-009 wb_data, mem_fwd_data  input  XLEN each  forwarding sources from WB and MEM.
REQ-010 forward_a, forward_b  input  2 each  operand forwarding selects.
REQ-011 alu_src  input  1  1 = operand B is imm.
REQ-012 aluop  input  2  op class; funct4  input  4  {funct7[5], funct3}.
REQ-013 out_valid  output  1  result registers hold valid data.
REQ-014 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-015 alu_result, branch_target  output  XLEN each  registered results.
REQ-016 zero  output  1  registered, alu_result == 0.
REQ-017 busy  output  1  iterative multiply in progress.

Function
REQ-018 Forward select: 00 register data, 01 wb_data, 10 mem_fwd_data, 11 register data.
REQ-019 Operand B: forwarded rs2 when alu_src=0, imm when alu_src=1.
REQ-020 branch_target: pc + (imm << 1), modulo 2^XLEN.
REQ-021 aluop 00 add; 01 sub; 10 decode funct4: 0000 add, 1000 sub, 0111 and, 0110 or, 0100 xor, 0001 sll, 0101 srl, 1101 sra, 0010 slt (signed, result 0/1), others add; 11 multiply (REQ-034).
REQ-022 Shifts use B[SHAMT_W-1:0] only; all arithmetic wraps modulo 2^XLEN.
REQ-023 Single-cycle op accepted at edge N: alu_result, branch_target, zero, out_valid=1 visible after edge N.
REQ-024 in_ready = !busy && (!out_valid || out_ready), combinational.
REQ-025 out_valid held with outputs stable while out_ready=0; cleared on transfer unless a new op loads that same edge.
REQ-026 Simultaneous output transfer and input accept: new result loaded, out_valid stays 1, no bubble.
REQ-027 Inputs sampled only at the accept edge; later changes to them do not affect an in-flight op.

Reset
REQ-028 rst_n=0 at a rising edge: out_valid=0, alu_result=0, branch_target=0, zero=0, busy=0, FSM IDLE.
REQ-029 Reset during a multiply aborts it; no result is produced.
REQ-030 in_ready is 0 while rst_n=0.

Configuration
REQ-031 Macro EXECUTE_MUL_EN selects multiply support.
REQ-032 Without EXECUTE_MUL_EN: aluop 11 executes add, busy tied 0, no FSM present.
REQ-033 With EXECUTE_MUL_EN: FSM states IDLE, MUL, DONE.
REQ-034 Multiply: IDLE->MUL on accept with aluop 11; one radix-2 shift-add step per cycle for XLEN cycles; MUL->DONE after last step; DONE loads low XLEN product bits, sets out_valid, ->IDLE; busy=1 in MUL and DONE.
REQ-035 Multiply latency: out_valid rises XLEN+1 edges after accept edge; DONE waits while out_valid && !out_ready.

Verification
REQ-036 XLEN=64, aluop=10, funct4=1000, rs1=5, rs2=7, fwd 00 -> next cycle alu_result=0xFFFF_FFFF_FFFF_FFFE, zero=0.
REQ-037 forward_a=10, mem_fwd_data=9, forward_b=01, wb_data=9, funct4=1000 -> alu_result=0, zero=1.
REQ-038 pc=0x1000, imm=-4 -> branch_target=0xFF8.
REQ-039 out_ready=0 two cycles with new in_valid -> in_ready=0, outputs unchanged; out_ready=1 -> back-to-back transfers, no bubble.
REQ-040 EXECUTE_MUL_EN, aluop=11, rs1=0x1_0000_0001, rs2=3 -> busy 1, out_valid after 65 edges, alu_result=0x3_0000_0003.
REQ-041 rst_n=0 at multiply cycle 10 -> out_valid 0, busy 0; next accepted add completes normally.

Source files
------------

// File: rtl/execute_stage_if.sv
// Handshake and data bundle between decode, the execute stage and memory.
// The slave modport is the execute stage itself; master is whoever drives it.
interface execute_stage_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] mem_fwd_data;
  logic [1:0]      forward_a;
  logic [1:0]      forward_b;
  logic            alu_src;
  logic [1:0]      aluop;
  logic [3:0]      funct4;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] branch_target;
  logic            zero;
  logic            busy;

  modport slave (
    input  in_valid, pc, imm, rs1_data, rs2_data, wb_data, mem_fwd_data,
           forward_a, forward_b, alu_src, aluop, funct4, out_ready,
    output in_ready, out_valid, alu_result, branch_target, zero, busy
  );

  modport master (
    output in_valid, pc, imm, rs1_data, rs2_data, wb_data, mem_fwd_data,
           forward_a, forward_b, alu_src, aluop, funct4, out_ready,
    input  in_ready, out_valid, alu_result, branch_target, zero, busy
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, branch target adder,
// registered valid/ready output. Define EXECUTE_MUL_EN to add an iterative
// radix-2 shift-add multiplier (aluop 11) controlled by an IDLE/MUL/DONE FSM;
// without it aluop 11 is an add and busy is tied low.
module execute_stage #(
  parameter int XLEN    = 64,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  execute_stage_if.slave bus
);

  logic [XLEN-1:0]    op_a_s;
  logic [XLEN-1:0]    op_b_s;
  logic [XLEN-1:0]    rs2_fwd_s;
  logic [XLEN-1:0]    alu_s;
  logic [XLEN-1:0]    bt_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic               accept_s;
  logic               out_xfer_s;
  logic               is_mul_s;
  logic               busy_s;

  logic               out_valid_r;
  logic [XLEN-1:0]    alu_result_r;
  logic [XLEN-1:0]    branch_target_r;
  logic               zero_r;

  assign accept_s   = bus.in_valid && bus.in_ready;
  assign out_xfer_s = out_valid_r && bus.out_ready;
  assign shamt_s    = op_b_s[SHAMT_W-1:0];
  assign bt_s       = bus.pc + (bus.imm << 1);

  // Operand selection: forwarding muxes for A and B, then immediate select for B.
  always_comb begin
    op_a_s    = bus.rs1_data;
    rs2_fwd_s = bus.rs2_data;
    case (bus.forward_a)
      2'b01:   op_a_s = bus.wb_data;
      2'b10:   op_a_s = bus.mem_fwd_data;
      default: op_a_s = bus.rs1_data;
    endcase
    case (bus.forward_b)
      2'b01:   rs2_fwd_s = bus.wb_data;
      2'b10:   rs2_fwd_s = bus.mem_fwd_data;
      default: rs2_fwd_s = bus.rs2_data;
    endcase
    if (bus.alu_src) begin
      op_b_s = bus.imm;
    end else begin
      op_b_s = rs2_fwd_s;
    end
  end

  // Single-cycle ALU; unknown funct4 codes and the multiply class fall back to add.
  always_comb begin
    alu_s = op_a_s + op_b_s;
    case (bus.aluop)
      2'b00: alu_s = op_a_s + op_b_s;
      2'b01: alu_s = op_a_s - op_b_s;
      2'b10: begin
        case (bus.funct4)
          4'b0000: alu_s = op_a_s + op_b_s;
          4'b1000: alu_s = op_a_s - op_b_s;
          4'b0111: alu_s = op_a_s & op_b_s;
          4'b0110: alu_s = op_a_s | op_b_s;
          4'b0100: alu_s = op_a_s ^ op_b_s;
          4'b0001: alu_s = op_a_s << shamt_s;
          4'b0101: alu_s = op_a_s >> shamt_s;
          4'b1101: alu_s = $unsigned($signed(op_a_s) >>> shamt_s);
          4'b0010: alu_s = {{(XLEN-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
          default: alu_s = op_a_s + op_b_s;
        endcase
      end
      default: alu_s = op_a_s + op_b_s;
    endcase
  end

  // Reset holds the stage closed so nothing is accepted while rst_n is low.
  assign bus.in_ready      = rst_n && !busy_s && (!out_valid_r || bus.out_ready);
  assign bus.out_valid     = out_valid_r;
  assign bus.alu_result    = alu_result_r;
  assign bus.branch_target = branch_target_r;
  assign bus.zero          = zero_r;

`ifdef EXECUTE_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'b00, MUL = 2'b01, DONE = 2'b10} state_t;

  state_t             state_r;
  logic               busy_r;
  logic [XLEN-1:0]    mcand_r;
  logic [XLEN-1:0]    mplier_r;
  logic [XLEN-1:0]    acc_r;
  logic [SHAMT_W-1:0] cnt_r;
  logic [XLEN-1:0]    mul_bt_r;

  assign is_mul_s = (bus.aluop == 2'b11);
  assign busy_s   = busy_r;
  assign bus.busy = busy_r;

  // Multiply FSM plus the output register: one shift-add step per MUL cycle,
  // DONE publishes the low product bits once the output slot is free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      busy_r          <= 1'b0;
      mcand_r         <= {XLEN{1'b0}};
      mplier_r        <= {XLEN{1'b0}};
      acc_r           <= {XLEN{1'b0}};
      cnt_r           <= {SHAMT_W{1'b0}};
      mul_bt_r        <= {XLEN{1'b0}};
      out_valid_r     <= 1'b0;
      alu_result_r    <= {XLEN{1'b0}};
      branch_target_r <= {XLEN{1'b0}};
      zero_r          <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && is_mul_s) begin
            mcand_r  <= op_a_s;
            mplier_r <= op_b_s;
            acc_r    <= {XLEN{1'b0}};
            cnt_r    <= {SHAMT_W{1'b0}};
            mul_bt_r <= bt_s;
            busy_r   <= 1'b1;
            state_r  <= MUL;
          end
        end
        MUL: begin
          acc_r    <= acc_r + (mplier_r[0] ? mcand_r : {XLEN{1'b0}});
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + {{(SHAMT_W-1){1'b0}}, 1'b1};
          if (cnt_r == SHAMT_W'(XLEN - 1)) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          if (!out_valid_r || bus.out_ready) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase

      if ((state_r == DONE) && (!out_valid_r || bus.out_ready)) begin
        out_valid_r     <= 1'b1;
        alu_result_r    <= acc_r;
        branch_target_r <= mul_bt_r;
        zero_r          <= (acc_r == {XLEN{1'b0}});
      end else if (accept_s && !is_mul_s) begin
        out_valid_r     <= 1'b1;
        alu_result_r    <= alu_s;
        branch_target_r <= bt_s;
        zero_r          <= (alu_s == {XLEN{1'b0}});
      end else if (out_xfer_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end
`else
  assign is_mul_s = 1'b0;
  assign busy_s   = 1'b0;
  assign bus.busy = 1'b0;

  // Output register: load on accept, drop valid on transfer, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r     <= 1'b0;
      alu_result_r    <= {XLEN{1'b0}};
      branch_target_r <= {XLEN{1'b0}};
      zero_r          <= 1'b0;
    end else if (accept_s && !is_mul_s) begin
      out_valid_r     <= 1'b1;
      alu_result_r    <= alu_s;
      branch_target_r <= bt_s;
      zero_r          <= (alu_s == {XLEN{1'b0}});
    end else if (out_xfer_s) begin
      out_valid_r <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage (XLEN=64): vector table streamed
// through a scoreboard, plus hand sequences for backpressure, reset and
// (when EXECUTE_MUL_EN is defined) the iterative multiply.
module tb_execute_stage;

  localparam int XLEN = 64;
`ifdef EXECUTE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0]  aluop;
    logic [3:0]  funct4;
    logic        alu_src;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] imm;
    logic [63:0] pc;
    logic [63:0] wb;
    logic [63:0] mem;
    logic [63:0] res;
    logic [63:0] bt;
    logic        zero;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [63:0] bt;
    logic        zero;
  } exp_t;

  logic clk;
  logic rst_n;
  int   applied;
  int   miscompares;
  exp_t sb_q[$];
  exp_t drv_exp;
  logic drv_mul;
  logic pending_single;
  vec_t tbl[16];

  execute_stage_if #(.XLEN(XLEN)) bus ();

  execute_stage #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] aluop, input logic [3:0] f4,
                              input logic src, input logic [1:0] fa, input logic [1:0] fb,
                              input logic [63:0] rs1, input logic [63:0] rs2,
                              input logic [63:0] imm, input logic [63:0] pc,
                              input logic [63:0] wb, input logic [63:0] mem,
                              input logic [63:0] res, input logic [63:0] bt,
                              input logic z);
    vec_t v;
    v.aluop = aluop; v.funct4 = f4; v.alu_src = src; v.fa = fa; v.fb = fb;
    v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc; v.wb = wb; v.mem = mem;
    v.res = res; v.bt = bt; v.zero = z;
    return v;
  endfunction

  task automatic present(input vec_t v);
    bus.aluop        = v.aluop;
    bus.funct4       = v.funct4;
    bus.alu_src      = v.alu_src;
    bus.forward_a    = v.fa;
    bus.forward_b    = v.fb;
    bus.rs1_data     = v.rs1;
    bus.rs2_data     = v.rs2;
    bus.imm          = v.imm;
    bus.pc           = v.pc;
    bus.wb_data      = v.wb;
    bus.mem_fwd_data = v.mem;
    drv_exp.res      = v.res;
    drv_exp.bt       = v.bt;
    drv_exp.zero     = v.zero;
    drv_mul          = MUL_EN && (v.aluop == 2'b11);
    bus.in_valid     = 1'b1;
  endtask

  // Present a vector and hold it until the accept edge has passed.
  task automatic send(input vec_t v);
    int w;
    present(v);
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 300) begin
      w++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      applied++;
      miscompares++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 300 cycles");
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare on output transfer, check one-edge latency, push on accept.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("alu_result", bus.alu_result, e.res);
          chk("branch_target", bus.branch_target, e.bt);
          chk("zero", {63'd0, bus.zero}, {63'd0, e.zero});
        end
      end
      if (pending_single) begin
        chk("single_cycle_valid", {63'd0, bus.out_valid}, 64'd1);
      end
      pending_single = bus.in_valid && bus.in_ready && !drv_mul;
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back(drv_exp);
      end
    end else begin
      pending_single = 1'b0;
    end
  end

  initial begin
    vec_t a, b, c, d, mv;
    int   k;
    logic saw_valid;
    applied = 0; miscompares = 0; pending_single = 1'b0; drv_mul = 1'b0;
    drv_exp.res = 64'd0; drv_exp.bt = 64'd0; drv_exp.zero = 1'b0;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    present(mk(2'b00, 4'b0000, 1'b0, 2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0,
               64'd0, 64'd0, 64'd0, 64'd0, 1'b1));
    bus.in_valid = 1'b0;

    // Table: {inputs, expected}
    tbl[0]  = mk(2'b10, 4'b1000, 1'b0, 2'b00, 2'b00, 64'd5, 64'd7, 64'd0, 64'd0, 64'd0, 64'd0,
                 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0);
    tbl[1]  = mk(2'b10, 4'b1000, 1'b0, 2'b10, 2'b01, 64'd1, 64'd2, 64'd0, 64'd0, 64'd9, 64'd9,
                 64'd0, 64'd0, 1'b1);
    tbl[2]  = mk(2'b00, 4'b0000, 1'b1, 2'b00, 2'b00, 64'd10, 64'd1000, 64'hFFFF_FFFF_FFFF_FFFC,
                 64'h1000, 64'd0, 64'd0, 64'd6, 64'hFF8, 1'b0);
    tbl[3]  = mk(2'b01, 4'b0000, 1'b0, 2'b00, 2'b00, 64'd100, 64'd1, 64'h10, 64'h100, 64'd0, 64'd0,
                 64'd99, 64'h120, 1'b0);
    tbl[4]  = mk(2'b10, 4'b0111, 1'b0, 2'b00, 2'b00, 64'hF0F0, 64'hFF00, 64'd0, 64'd0, 64'd0, 64'd0,
                 64'hF000, 64'd0, 1'b0);
    tbl[5]  = mk(2'b10, 4'b0110, 1'b0, 2'b00, 2'b00, 64'hF0F0, 64'h0F0F, 64'd0, 64'd0, 64'd0, 64'd0,
                 64'hFFFF, 64'd0, 1'b0);
    tbl[6]  = mk(2'b10, 4'b0100, 1'b0, 2'b00, 2'b00, 64'hFF, 64'h0F, 64'd0, 64'd0, 64'd0, 64'd0,
                 64'hF0, 64'd0, 1'b0);
    tbl[7]  = mk(2'b10, 4'b0001, 1'b0, 2'b00, 2'b00, 64'd1, 64'h43, 64'd0, 64'd0, 64'd0, 64'd0,
                 64'd8, 64'd0, 1'b0);
    tbl[8]  = mk(2'b10, 4'b0101, 1'b0, 2'b00, 2'b00, 64'h8000_0000_0000_0000, 64'd63, 64'd0, 64'd0,
                 64'd0, 64'd0, 64'd1, 64'd0, 1'b0);
    tbl[9]  = mk(2'b10, 4'b1101, 1'b0, 2'b00, 2'b00, 64'h8000_0000_0000_0000, 64'd63, 64'd0, 64'd0,
                 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
    tbl[10] = mk(2'b10, 4'b0010, 1'b0, 2'b00, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0,
                 64'd0, 64'd0, 64'd1, 64'd0, 1'b0);
    tbl[11] = mk(2'b10, 4'b0010, 1'b0, 2'b00, 2'b00, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0,
                 64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
    tbl[12] = mk(2'b10, 4'b0011, 1'b0, 2'b00, 2'b00, 64'd3, 64'd4, 64'd0, 64'd0, 64'd0, 64'd0,
                 64'd7, 64'd0, 1'b0);
    tbl[13] = mk(2'b00, 4'b0000, 1'b0, 2'b11, 2'b11, 64'd2, 64'd3, 64'd0, 64'd0, 64'd100, 64'd200,
                 64'd5, 64'd0, 1'b0);
    tbl[14] = mk(2'b00, 4'b0000, 1'b0, 2'b00, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0,
                 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    tbl[15] = mk(2'b11, 4'b0000, 1'b0, 2'b00, 2'b00, 64'd6, 64'd7, 64'd0, 64'd0, 64'd0, 64'd0,
                 MUL_EN ? 64'd42 : 64'd13, 64'd0, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_alu_result", bus.alu_result, 64'd0);
    chk("rst_branch_target", bus.branch_target, 64'd0);
    chk("rst_zero", {63'd0, bus.zero}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Vector table streamed back-to-back
    for (int i = 0; i < 16; i++) begin
      send(tbl[i]);
    end
    idle(3);

    // Backpressure: hold A while B waits, then release for back-to-back flow
    a = mk(2'b00, 4'b0000, 1'b0, 2'b00, 2'b00, 64'd1, 64'd2, 64'd0, 64'h40, 64'd0, 64'd0,
           64'd3, 64'h40, 1'b0);
    b = mk(2'b01, 4'b0000, 1'b0, 2'b00, 2'b00, 64'd10, 64'd4, 64'd0, 64'd0, 64'd0, 64'd0,
           64'd6, 64'd0, 1'b0);
    c = mk(2'b10, 4'b0100, 1'b0, 2'b00, 2'b00, 64'd5, 64'd3, 64'd0, 64'd0, 64'd0, 64'd0,
           64'd6, 64'd0, 1'b0);
    d = mk(2'b10, 4'b0111, 1'b0, 2'b00, 2'b00, 64'hC, 64'hA, 64'd0, 64'd0, 64'd0, 64'd0,
           64'd8, 64'd0, 1'b0);
    bus.out_ready = 1'b0;
    send(a);
    present(b);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("hold_alu_result", bus.alu_result, a.res);
      chk("hold_branch_target", bus.branch_target, a.bt);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(b);
    send(c);
    send(d);
    idle(3);

    if (MUL_EN) begin
      // Multiply latency and result
      mv = mk(2'b11, 4'b0000, 1'b0, 2'b00, 2'b00, 64'h1_0000_0001, 64'd3, 64'd0, 64'd0, 64'd0,
              64'd0, 64'h3_0000_0003, 64'd0, 1'b0);
      send(mv);
      chk("mul_busy", {63'd0, bus.busy}, 64'd1);
      chk("mul_in_ready", {63'd0, bus.in_ready}, 64'd0);
      k = 0;
      while (!bus.out_valid && k < 200) begin
        @(posedge clk);
        #1;
        k++;
      end
      chk("mul_latency", 64'(k), 64'd65);
      idle(3);

      // Reset aborts an in-flight multiply
      send(mv);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("abort_busy", {63'd0, bus.busy}, 64'd0);
      sb_q.delete();
      rst_n = 1'b1;
      saw_valid = 1'b0;
      for (int i = 0; i < 70; i++) begin
        @(negedge clk);
        if (bus.out_valid) saw_valid = 1'b1;
      end
      chk("abort_no_result", {63'd0, saw_valid}, 64'd0);
      @(posedge clk);
      #1;
      send(a);
      idle(3);
    end

    // Reset mid-stream with a held result, then a normal op
    bus.out_ready = 1'b0;
    send(c);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst2_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst2_alu_result", bus.alu_result, 64'd0);
    sb_q.delete();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(d);
    idle(3);

    k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
